updown_counter_param: RTL and testbench



---
 rtl/updown_counter_param.sv | 83 ++++++++
 tb/tb_updown_counter_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with programmable modulus, wrap or
// saturate behaviour, parallel load, cascade terminal count and sticky flags.
module updown_counter_param #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter bit              SAT_MODE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max_s, at_zero_s;
  logic [WIDTH-1:0] load_clamped_s;

  assign at_max_s       = (cnt_q == MAX_VAL);
  assign at_zero_s      = (cnt_q == ZERO);
  assign load_clamped_s = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Next-state: load beats enable; a boundary crossing sets its flag, and a
  // set in the same cycle as clr_flags wins because it is applied last.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~clr_flags;
    unf_d = unf_q & ~clr_flags;
    if (load) begin
      cnt_d = load_clamped_s;
    end else if (en) begin
      if (ud) begin
        if (at_max_s) begin
          ovf_d = 1'b1;
          cnt_d = SAT_MODE ? cnt_q : ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (at_zero_s) begin
          unf_d = 1'b1;
          cnt_d = SAT_MODE ? cnt_q : MAX_VAL;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RESET_VAL;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Cascade carry stays combinational so chained stages step on the same edge.
  assign tc    = en & ~load & ~rst & ((ud & at_max_s) | (~ud & at_zero_s));
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: four counter configurations share one stimulus stream and
// are checked against an integer reference model of the counting rules.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst, en, ud, load, clr_flags;
  logic [7:0] load_val;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic [7:0] cnt_d;
  logic [3:0] tc_v, ovf_v, unf_v;

  always #5 clk = ~clk;

  // A: decade wrap, B: 4-bit saturate, C: decade with reset value 7, D: defaults
  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b0), .RESET_VAL(4'd0)) u_a (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val[3:0]),
    .clr_flags(clr_flags), .count(cnt_a), .tc(tc_v[0]), .ovf(ovf_v[0]), .unf(unf_v[0]));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd15), .SAT_MODE(1'b1), .RESET_VAL(4'd0)) u_b (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val[3:0]),
    .clr_flags(clr_flags), .count(cnt_b), .tc(tc_v[1]), .ovf(ovf_v[1]), .unf(unf_v[1]));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b0), .RESET_VAL(4'd7)) u_c (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val[3:0]),
    .clr_flags(clr_flags), .count(cnt_c), .tc(tc_v[2]), .ovf(ovf_v[2]), .unf(unf_v[2]));
  updown_counter_param #(.WIDTH(8)) u_d (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_d), .tc(tc_v[3]), .ovf(ovf_v[3]), .unf(unf_v[3]));

  int max_v[4] = '{9, 15, 9, 255};
  bit sat_v[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int rst_v[4] = '{0, 0, 7, 0};

  int m_cnt[4];
  bit m_ovf[4];
  bit m_unf[4];

  typedef struct {
    bit tc[4];
    int cnt[4];
    bit ovf[4];
    bit unf[4];
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int dut, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, dut, got, want, $time);
    end
  endtask

  // Apply one cycle of stimulus and record what every configuration must do.
  task automatic cycle(input bit r, input bit e, input bit u, input bit l,
                       input int lv, input bit c);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; ud = u; load = l; load_val = lv[7:0]; clr_flags = c;
    for (int i = 0; i < 4; i++) begin
      int lvi;
      lvi = (i == 3) ? (lv % 256) : (lv % 16);
      x.tc[i] = e && !l && !r &&
                ((u && m_cnt[i] == max_v[i]) || (!u && m_cnt[i] == 0));
      if (r) begin
        m_cnt[i] = rst_v[i];
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
      end else begin
        if (c) begin
          m_ovf[i] = 1'b0;
          m_unf[i] = 1'b0;
        end
        if (l) begin
          m_cnt[i] = (lvi > max_v[i]) ? max_v[i] : lvi;
        end else if (e && u) begin
          if (m_cnt[i] < max_v[i]) m_cnt[i] = m_cnt[i] + 1;
          else begin
            m_ovf[i] = 1'b1;
            if (!sat_v[i]) m_cnt[i] = 0;
          end
        end else if (e && !u) begin
          if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
          else begin
            m_unf[i] = 1'b1;
            if (!sat_v[i]) m_cnt[i] = max_v[i];
          end
        end
      end
      x.cnt[i] = m_cnt[i];
      x.ovf[i] = m_ovf[i];
      x.unf[i] = m_unf[i];
    end
    exp_q.push_back(x);
  endtask

  // Monitor: tc is sampled late in the low phase, registered outputs after the edge.
  initial begin
    bit   tc_s[4];
    int   got[4];
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      for (int i = 0; i < 4; i++) tc_s[i] = tc_v[i];
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        got[0] = int'(cnt_a); got[1] = int'(cnt_b);
        got[2] = int'(cnt_c); got[3] = int'(cnt_d);
        for (int i = 0; i < 4; i++) begin
          check("tc",    i, int'(tc_s[i]),  int'(x.tc[i]));
          check("count", i, got[i],         x.cnt[i]);
          check("ovf",   i, int'(ovf_v[i]), int'(x.ovf[i]));
          check("unf",   i, int'(unf_v[i]), int'(x.unf[i]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; ud = 1'b1; load = 1'b0; load_val = 8'd0; clr_flags = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end

    // Decade wrap then down wrap with a direction change
    cycle(1, 0, 1, 0, 0, 0);
    repeat (12) cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (5) cycle(0, 1, 0, 0, 0, 0);

    // Saturation from a loaded value in both directions
    cycle(0, 0, 1, 1, 14, 0);
    repeat (4) cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 0);
    repeat (3) cycle(0, 1, 0, 0, 0, 0);

    // Load priority over enable and out-of-range clamping
    cycle(0, 0, 1, 1, 5, 0);
    cycle(0, 1, 1, 1, 12, 0);
    cycle(0, 1, 1, 1, 4, 0);

    // Flag clear alone, then clear racing a wrap
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 1, 9, 0);
    cycle(0, 1, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 0);

    // Reset overriding a load mid-count, then count up from the reset value
    cycle(0, 0, 1, 1, 3, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 2, 1);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0),
            $urandom_range(0, 255),
            ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("drain", 0, exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
